aud_recorder: RTL

- Capture-side counterpart of the DAC playback path: receives the WM8731 ADC serial stream (I2S format, left channel only) and writes each 16-bit sample into SRAM as one word at consecutive addresses.
- Sits inside the lab-3 Top between the codec pins (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) and the SRAM arbiter.
- Driven by the debounced record/pause/stop key pulses.
- Reports the recorded sample count so playback knows where the recording ends.

---
 rtl/aud_recorder_if.sv | 27 ++
 rtl/aud_recorder.sv | 82 ++++++++
 2 files changed

// File: rtl/aud_recorder_if.sv
// aud_recorder_if: codec, command and SRAM-write signals of the ADC recorder
interface aud_recorder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20
);
   logic              i_start;
   logic              i_pause;
   logic              i_stop;
   logic              i_bclk;
   logic              i_lrc;
   logic              i_adcdat;
   logic [ADDR_W-1:0] o_address;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              o_recording;
   logic              o_paused;
   logic              o_full;
   logic [ADDR_W:0]   o_sample_cnt;
   modport master (
      output i_start, i_pause, i_stop, i_bclk, i_lrc, i_adcdat,
      input  o_address, o_data, o_valid, o_recording, o_paused, o_full, o_sample_cnt
   );
   modport slave (
      input  i_start, i_pause, i_stop, i_bclk, i_lrc, i_adcdat,
      output o_address, o_data, o_valid, o_recording, o_paused, o_full, o_sample_cnt
   );
endinterface

// File: rtl/aud_recorder.sv
// aud_recorder: captures the left I2S ADC channel and writes one SRAM word per frame
module aud_recorder #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
   input logic          i_clk,
   input logic          i_rst,
   aud_recorder_if.slave bus
);
   localparam int CW = $clog2(DATA_W);
   typedef enum logic [2:0] {IDLE, WAIT_LR, SKIP, SHIFT, STORE, PAUSED, FULL} state_t;
   state_t state, nxt;
   logic [2:0] bclk_q;
   logic [1:0] lrc_q, dat_q;
   logic lrc_last, pend, rise, lrc_fall, stop, pause, start, last;
   logic [DATA_W-1:0] sr;
   logic [CW-1:0] bit_cnt;
   logic [ADDR_W-1:0] addr;
   assign rise     = bclk_q[1] & ~bclk_q[2];
   assign lrc_fall = rise & lrc_last & ~lrc_q[1];
   assign stop     = bus.i_stop;
   assign pause    = bus.i_pause & ~stop;
   assign start    = bus.i_start & ~bus.i_pause & ~stop;
   assign last     = rise && bit_cnt == CW'(DATA_W - 1);
   assign bus.o_recording = state inside {WAIT_LR, SKIP, SHIFT, STORE};
   assign bus.o_paused    = state == PAUSED;
   assign bus.o_full      = state == FULL;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, FULL: nxt = start ? WAIT_LR : stop ? IDLE : state;
         WAIT_LR:    nxt = stop ? IDLE : pause ? PAUSED : lrc_fall ? SKIP : WAIT_LR;
         SKIP:       nxt = stop ? IDLE : pause ? PAUSED : SHIFT;
         SHIFT:      nxt = stop ? IDLE : last ? STORE : SHIFT;
         STORE:      nxt = stop ? IDLE : addr == MAX_ADDR ? FULL : (pend || pause) ? PAUSED : WAIT_LR;
         PAUSED:     nxt = stop ? IDLE : start ? WAIT_LR : PAUSED;
         default:    nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state            <= IDLE;
         bclk_q           <= '0;
         lrc_q            <= '0;
         dat_q            <= '0;
         lrc_last         <= 1'b0;
         pend             <= 1'b0;
         sr               <= '0;
         bit_cnt          <= '0;
         addr             <= '0;
         bus.o_address    <= '0;
         bus.o_data       <= '0;
         bus.o_valid      <= 1'b0;
         bus.o_sample_cnt <= '0;
      end else begin
         state    <= nxt;
         bclk_q   <= {bclk_q[1:0], bus.i_bclk};
         lrc_q    <= {lrc_q[0], bus.i_lrc};
         dat_q    <= {dat_q[0], bus.i_adcdat};
         // LRC history only advances on BCLK rises so a fall is seen exactly once
         if (rise) lrc_last <= lrc_q[1];
         pend        <= state == SHIFT && (pend || pause);
         bus.o_valid <= state == STORE;
         if (state == SKIP) bit_cnt <= '0;
         if (state == SHIFT && rise) begin
            sr      <= {sr[DATA_W-2:0], dat_q[1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if ((state == IDLE || state == FULL) && nxt == WAIT_LR) begin
            addr             <= '0;
            bus.o_sample_cnt <= '0;
         end
         if (state == STORE) begin
            bus.o_data       <= sr;
            bus.o_address    <= addr;
            bus.o_sample_cnt <= bus.o_sample_cnt + 1'b1;
            if (addr != MAX_ADDR) addr <= addr + 1'b1;
         end
      end
   end
endmodule
